layer_out_sequencer: RTL and testbench

- Sits between two neuron layers. Captures the parallel output vector of layer N (NN values, all fired together) and replays it as a serial stream for layer N+1.
- Layer N+1 consumes one value per cycle on its shared `x_in`/`x_valid` inputs.
- Reports layer completion and flags protocol errors (partial valid vector, overrun).
- Optional on-the-fly argmax for the final (classification) layer.

---
 rtl/layer_out_sequencer_if.sv | 30 +++
 rtl/layer_out_sequencer.sv | 113 +++++++++++
 tb/tb_layer_out_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/layer_out_sequencer_if.sv
// Bus bundle between a parallel-output neuron layer, the serialising sequencer and the next layer.
interface layer_out_sequencer_if #(
  parameter int NN        = 10,
  parameter int dataWidth = 16,
  parameter int IDXW      = 4
);
  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic                    x_valid;
  logic [dataWidth-1:0]    x_out;
  logic [IDXW-1:0]         x_idx;
  logic                    busy;
  logic                    layer_done;
  logic                    partial_err;
  logic                    overrun_err;
  logic [IDXW-1:0]         argmax_idx;
  logic                    argmax_valid;

  modport slave (
    input  i_valid, i_data,
    output x_valid, x_out, x_idx, busy, layer_done,
           partial_err, overrun_err, argmax_idx, argmax_valid
  );

  modport master (
    output i_valid, i_data,
    input  x_valid, x_out, x_idx, busy, layer_done,
           partial_err, overrun_err, argmax_idx, argmax_valid
  );
endinterface

// File: rtl/layer_out_sequencer.sv
// Captures a layer's parallel output vector and replays it one element per cycle.
// Optional signed argmax tracker enabled by defining LAYER_ARGMAX_EN.
module layer_out_sequencer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16,
  parameter int IDXW      = 4
) (
  input logic                  clk,
  input logic                  rst,
  layer_out_sequencer_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_nx;
  logic [IDXW-1:0]      cnt;
  logic [dataWidth-1:0] data_buf [NN];
  logic                 done_q;
  logic                 partial_q;
  logic                 overrun_q;
  logic                 cap_req;
  logic                 last;

  assign cap_req = bus.i_valid[0];
  assign last    = (cnt == IDXW'(NN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cap_req) state_nx = SEND;
      SEND:    if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cnt parks on the last index after a stream so x_out/x_idx hold their final value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      done_q    <= 1'b0;
      partial_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned k = 0; k < NN; k++) data_buf[k] <= '0;
    end else begin
      done_q <= (state == SEND) && last;
      if ((bus.i_valid != '0) && (bus.i_valid != '1)) partial_q <= 1'b1;
      if ((state == SEND) && cap_req) overrun_q <= 1'b1;
      if ((state == IDLE) && cap_req) begin
        cnt <= '0;
        for (int unsigned k = 0; k < NN; k++)
          data_buf[k] <= bus.i_data[k*dataWidth +: dataWidth];
      end else if ((state == SEND) && !last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef LAYER_ARGMAX_EN
  logic signed [dataWidth-1:0] max_val;
  logic [IDXW-1:0]             max_idx;
  logic [IDXW-1:0]             amax_idx_q;
  logic                        amax_v_q;
  logic                        take;
  logic [IDXW-1:0]             idx_nx;

  // Strict greater-than keeps the lower index on ties; element 0 always seeds the tracker.
  always_comb begin
    take   = (cnt == '0) || ($signed(data_buf[cnt]) > max_val);
    idx_nx = take ? cnt : max_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val    <= '0;
      max_idx    <= '0;
      amax_idx_q <= '0;
      amax_v_q   <= 1'b0;
    end else begin
      amax_v_q <= (state == SEND) && last;
      if (state == SEND) begin
        if (take) begin
          max_val <= $signed(data_buf[cnt]);
          max_idx <= cnt;
        end
        if (last) amax_idx_q <= idx_nx;
      end
    end
  end
`endif

  always_comb begin
    bus.x_valid     = (state == SEND);
    bus.busy        = (state == SEND);
    bus.x_out       = data_buf[cnt];
    bus.x_idx       = cnt;
    bus.layer_done  = done_q;
    bus.partial_err = partial_q;
    bus.overrun_err = overrun_q;
`ifdef LAYER_ARGMAX_EN
    bus.argmax_idx   = amax_idx_q;
    bus.argmax_valid = amax_v_q;
`else
    bus.argmax_idx   = '0;
    bus.argmax_valid = 1'b0;
`endif
  end

endmodule

// File: tb/tb_layer_out_sequencer.sv
// Directed and randomized bench for layer_out_sequencer against a vector-level reference model.
module tb_layer_out_sequencer;
  localparam int NN = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] vec [NN];
  logic          exp_partial = 1'b0;
  logic          exp_overrun = 1'b0;
  logic [IW-1:0] exp_amax    = '0;

  layer_out_sequencer_if #(.NN(NN), .dataWidth(DW), .IDXW(IW)) bus ();

  layer_out_sequencer #(.NN(NN), .dataWidth(DW), .IDXW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] ref_argmax();
    int best = 0;
    for (int k = 1; k < NN; k++)
      if ($signed(vec[k]) > $signed(vec[best])) best = k;
    return IW'(best);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".x_valid"}, 32'(bus.x_valid), 0);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".layer_done"}, 32'(bus.layer_done), 0);
    check({tag, ".argmax_valid"}, 32'(bus.argmax_valid), 0);
    check({tag, ".partial_err"}, 32'(bus.partial_err), 32'(exp_partial));
    check({tag, ".overrun_err"}, 32'(bus.overrun_err), 32'(exp_overrun));
    check({tag, ".argmax_idx"}, 32'(bus.argmax_idx), 32'(exp_amax));
  endtask

  task automatic check_reset_state(input string tag);
    check_quiet(tag);
    check({tag, ".x_out"}, 32'(bus.x_out), 0);
    check({tag, ".x_idx"}, 32'(bus.x_idx), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_partial = 1'b0;
    exp_overrun = 1'b0;
    exp_amax    = '0;
    check_reset_state("after_rst");
  endtask

  // Present vec with the given valid pattern, then check the whole stream and the done cycle.
  // ovr_at >= 0 injects a second capture while element ovr_at is on the bus.
  task automatic send(input logic [NN-1:0] cap, input int ovr_at);
    logic [NN*DW-1:0] pk;
    for (int k = 0; k < NN; k++) pk[k*DW +: DW] = vec[k];
    bus.i_valid = cap;
    bus.i_data  = pk;
    if (cap != '0 && cap != '1) exp_partial = 1'b1;
    step();
    bus.i_valid = '0;
    for (int k = 0; k < NN; k++) begin
      check($sformatf("s%0d.x_valid", k), 32'(bus.x_valid), 1);
      check($sformatf("s%0d.x_out", k), 32'(bus.x_out), 32'(vec[k]));
      check($sformatf("s%0d.x_idx", k), 32'(bus.x_idx), 32'(k));
      check($sformatf("s%0d.busy", k), 32'(bus.busy), 1);
      check($sformatf("s%0d.layer_done", k), 32'(bus.layer_done), 0);
      check($sformatf("s%0d.argmax_valid", k), 32'(bus.argmax_valid), 0);
      check($sformatf("s%0d.partial_err", k), 32'(bus.partial_err), 32'(exp_partial));
      check($sformatf("s%0d.overrun_err", k), 32'(bus.overrun_err), 32'(exp_overrun));
      if (k == ovr_at) begin
        bus.i_valid = '1;
        bus.i_data  = ~pk;
      end
      step();
      bus.i_valid = '0;
      if (k == ovr_at) exp_overrun = 1'b1;
    end
`ifdef LAYER_ARGMAX_EN
    exp_amax = ref_argmax();
    check("done.argmax_valid", 32'(bus.argmax_valid), 1);
`else
    check("done.argmax_valid", 32'(bus.argmax_valid), 0);
`endif
    check("done.layer_done", 32'(bus.layer_done), 1);
    check("done.x_valid", 32'(bus.x_valid), 0);
    check("done.busy", 32'(bus.busy), 0);
    check("done.x_out_hold", 32'(bus.x_out), 32'(vec[NN-1]));
    check("done.x_idx_hold", 32'(bus.x_idx), NN - 1);
    check("done.argmax_idx", 32'(bus.argmax_idx), 32'(exp_amax));
    check("done.overrun_err", 32'(bus.overrun_err), 32'(exp_overrun));
  endtask

  task automatic rand_vec();
    for (int k = 0; k < NN; k++) vec[k] = DW'($urandom);
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_valid = '0;
    bus.i_data  = '0;
    repeat (3) step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) check_reset_state("idle");

    // basic stream
    for (int k = 0; k < NN; k++) vec[k] = DW'(16'h0100 + k);
    send('1, -1);
    step();
    check_quiet("post_basic");

    // overrun during element 4 (cycle T+5): stream unchanged, second vector dropped
    rand_vec();
    send('1, 4);
    for (int c = 0; c < 5; c++) begin
      step();
      check_quiet("post_ovr");
    end
    do_reset();

    // back-to-back: recapture in the layer_done cycle
    rand_vec();
    send('1, -1);
    rand_vec();
    send('1, -1);
    step();
    check_quiet("post_b2b");

    // partial valid still captures on bit 0
    rand_vec();
    send(10'b0000000011, -1);
    step();
    check_quiet("post_partial");
    do_reset();

    // argmax: tie at 2/3 keeps lower index
    vec[0] = DW'(5); vec[1] = DW'(-3); vec[2] = DW'(9); vec[3] = DW'(9); vec[4] = DW'(2);
    for (int k = 5; k < NN; k++) vec[k] = DW'(k - 5);
    send('1, -1);
    step();
    // argmax: all negative, max -1 at index 7
    for (int k = 0; k < NN; k++) vec[k] = DW'(-(k + 20));
    vec[7] = DW'(-1);
    send('1, -1);
    step();
    check_quiet("amax_hold");

    // randomized vectors with random gaps, including both extremes of the signed range
    for (int n = 0; n < 8; n++) begin
      rand_vec();
      if (n == 0) begin
        vec[$urandom_range(NN - 1)] = 16'h7fff;
        vec[$urandom_range(NN - 1)] = 16'h8000;
      end
      send('1, -1);
      for (int g = 0; g < int'($urandom_range(3)); g++) begin
        step();
        check_quiet("rand_gap");
      end
    end

    // reset mid-stream: no layer_done, no argmax_valid
    rand_vec();
    bus.i_valid = '1;
    for (int k = 0; k < NN; k++) bus.i_data[k*DW +: DW] = vec[k];
    step();
    bus.i_valid = '0;
    repeat (3) step();
    check("mid.x_valid", 32'(bus.x_valid), 1);
    check("mid.x_idx", 32'(bus.x_idx), 3);
    do_reset();
    for (int c = 0; c < NN + 2; c++) begin
      step();
      check_reset_state("abort");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
